// File: rtl/unidad_mult_div_pkg.sv
// unidad_mult_div_pkg: constants shared by the multiply/divide unit and the decode stage.
// Holds operand width, OP encodings and the FSM state encoding.
// No ports; import with `import unidad_mult_div_pkg::*;`.
package unidad_mult_div_pkg;

  localparam int MD_W = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } md_state_t;

  // Bit 1 of OP selects divide, bit 0 selects signed.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/unidad_mult_div.sv
// unidad_mult_div: iterative 32x32 multiply (shift-add) / 32/32 divide (restoring), HI/LO result registers.
// Latency: accept edge E0, W iterations on E1..EW, sign fix and HI/LO write on EW+1 with DONE pulse.
// Backpressure: START is sampled only while BUSY=0; requests during CALC/FIX are dropped, not queued.
// Ports: clk, rst_n (async active-low); start, op[1:0], a, b in; busy, done, hi, lo, div0 out.
module unidad_mult_div
  import unidad_mult_div_pkg::*;
#(
  parameter int W = MD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         div0
);

  md_state_t state_q, state_d;

  logic [5:0]     cnt_q;
  logic [2*W-1:0] acc_q;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]   opnd_q;     // mult: |multiplicand|; div: |divisor|
  logic           is_div_q;
  logic           neg_main_q; // negate product / quotient
  logic           neg_rem_q;  // negate remainder
  logic           div0_pend_q;
  logic           done_q;
  logic [W-1:0]   hi_q, lo_q;
  logic           div0_q;

  // Two's-complement conditional negate, used both for magnitudes and for the final fix.
  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Accept-time operand conditioning.
  logic           acc_sa, acc_sb;
  logic [W-1:0]   mag_a, mag_b;

  always_comb begin
    acc_sa = op_is_signed(op) & a[W-1];
    acc_sb = op_is_signed(op) & b[W-1];
    mag_a  = cond_neg(a, acc_sa);
    mag_b  = cond_neg(b, acc_sb);
  end

  // One iteration of each datapath.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shl;
  logic [W:0]     div_trial;
  logic [2*W-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
    mul_next = {mul_sum, acc_q[W-1:1]};

    // Shifted partial remainder is W+1 bits; explicit compare keeps the
    // divide-by-zero case well defined (quotient all ones, remainder = dividend).
    div_shl   = acc_q[2*W-1:W-1];
    div_trial = div_shl - {1'b0, opnd_q};
    if (div_shl >= {1'b0, opnd_q}) begin
      div_next = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_next = {acc_q[2*W-2:0], 1'b0};
    end
  end

  // Final result after sign fix.
  logic [2*W-1:0] prod_fix;

  always_comb begin
    prod_fix = neg_main_q ? (~acc_q + 1'b1) : acc_q;
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt_q == 6'(W - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      is_div_q    <= 1'b0;
      neg_main_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_pend_q <= 1'b0;
      done_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      div0_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q       <= '0;
            is_div_q    <= op_is_div(op);
            neg_main_q  <= acc_sa ^ acc_sb;
            neg_rem_q   <= acc_sa;
            div0_pend_q <= op_is_div(op) && (b == '0);
            if (op_is_div(op)) begin
              acc_q  <= {{W{1'b0}}, mag_a};
              opnd_q <= mag_b;
            end else begin
              acc_q  <= {{W{1'b0}}, mag_b};
              opnd_q <= mag_a;
            end
          end
        end
        S_CALC: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 6'd1;
        end
        S_FIX: begin
          done_q <= 1'b1;
          div0_q <= div0_pend_q;
          if (is_div_q) begin
            // Remainder sign fix also restores HI = A on divide by zero.
            hi_q <= cond_neg(acc_q[2*W-1:W], neg_rem_q);
            lo_q <= div0_pend_q ? {W{1'b1}} : cond_neg(acc_q[W-1:0], neg_main_q);
          end else begin
            hi_q <= prod_fix[2*W-1:W];
            lo_q <= prod_fix[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign div0 = div0_q;

endmodule
